// File: rtl/pc_fetch_seq_if.sv
// Fetch-side bundle: next-PC redirect input, instruction-memory req/gnt/rvalid port
// and the valid/ready instruction handoff to Issue.
interface pc_fetch_seq_if;
    logic [31:0] pc_next_i;
    logic        pc_next_valid_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        fetch_err_o;

    modport master (
        input  pc_next_i, pc_next_valid_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i,
               instr_ready_i,
        output instr_req_o, instr_addr_o, instr_valid_o, instr_rdata_o, instr_pc_o,
               fetch_err_o
    );

    modport slave (
        output pc_next_i, pc_next_valid_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i,
               instr_ready_i,
        input  instr_req_o, instr_addr_o, instr_valid_o, instr_rdata_o, instr_pc_o,
               fetch_err_o
    );
endinterface

// File: rtl/pc_fetch_seq.sv
// Single-outstanding sequential instruction fetcher with next-PC redirect and stale-data discard.
// Macro PC_FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect flag fetch_err_o.
module pc_fetch_seq #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input logic            clk_i,
    input logic            rst_i,
    pc_fetch_seq_if.master bus
);
    localparam logic [31:0] BootPc = {BOOT_ADDR[31:2], 2'b00};

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic [31:0] pc_q;
    logic        discard_q;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_target;

    always_comb begin
        redirect    = bus.pc_next_valid_i;
        redirect_pc = {bus.pc_next_i[31:2], 2'b00};
        // Address of the next request launched this cycle; a redirect wins over the held PC.
        pc_target   = redirect ? redirect_pc : fetch_pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= BootPc;
            discard_q  <= 1'b0;
            addr_q     <= 32'h0;
            rdata_q    <= 32'h0;
            pc_q       <= 32'h0;
        end else begin
            if (redirect) begin
                fetch_pc_q <= redirect_pc;
            end
            unique case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    addr_q  <= pc_target;
                end
                StReq: begin
                    // The in-flight request keeps its address; its response becomes stale.
                    if (redirect) begin
                        discard_q <= 1'b1;
                    end
                    if (bus.instr_gnt_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.instr_rvalid_i) begin
                        if (discard_q || redirect) begin
                            discard_q <= 1'b0;
                            state_q   <= StReq;
                            addr_q    <= pc_target;
                        end else begin
                            rdata_q    <= bus.instr_rdata_i;
                            pc_q       <= addr_q;
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                            state_q    <= StHold;
                        end
                    end else if (redirect) begin
                        discard_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (bus.instr_ready_i || redirect) begin
                        state_q <= StReq;
                        addr_q  <= pc_target;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.instr_req_o   = (state_q == StReq);
    assign bus.instr_addr_o  = addr_q;
    assign bus.instr_valid_o = (state_q == StHold);
    assign bus.instr_rdata_o = rdata_q;
    assign bus.instr_pc_o    = pc_q;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (redirect && (bus.pc_next_i[1:0] != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.fetch_err_o = err_q;
`else
    logic unused_pc_low;
    assign unused_pc_low   = ^bus.pc_next_i[1:0];
    assign bus.fetch_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_seq.sv
// Self-checking bench for pc_fetch_seq: directed scenarios plus a randomized run
// scored against a transaction-level fetch model.
module tb_pc_fetch_seq;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    pc_fetch_seq_if bus ();

    pc_fetch_seq #(
        .BOOT_ADDR(32'h0000_0080)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                          input logic rdy, input logic redir, input logic [31:0] tgt);
        bus.instr_gnt_i     = g;
        bus.instr_rvalid_i  = rv;
        bus.instr_rdata_i   = rd;
        bus.instr_ready_i   = rdy;
        bus.pc_next_valid_i = redir;
        bus.pc_next_i       = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        // Reset must win over a concurrent misaligned redirect.
        set_in(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0103);
        repeat (2) @(negedge clk);
        tests_run += 6;
        if (bus.instr_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_req: got %b want 0", bus.instr_req_o);
        end
        if (bus.instr_addr_o !== 32'h0) begin
            tests_failed++; $display("FAIL reset_addr: got %h want 0", bus.instr_addr_o);
        end
        if (bus.instr_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid_o);
        end
        if (bus.instr_rdata_o !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rdata: got %h want 0", bus.instr_rdata_o);
        end
        if (bus.instr_pc_o !== 32'h0) begin
            tests_failed++; $display("FAIL reset_pc: got %h want 0", bus.instr_pc_o);
        end
        if (bus.fetch_err_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_err: got %b want 0", bus.fetch_err_o);
        end
        rst = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_basic_fetch();
        @(negedge clk);
        tests_run += 2;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h80) begin
            tests_failed++;
            $display("FAIL boot_req: got req=%b addr=%h want req=1 addr=00000080",
                     bus.instr_req_o, bus.instr_addr_o);
        end
        if (bus.instr_valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL boot_valid: got %b want 0", bus.instr_valid_o);
        end
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL wait_req: got %b want 0", bus.instr_req_o);
        end
        set_in(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h80 ||
            bus.instr_rdata_o !== 32'h13) begin
            tests_failed++;
            $display("FAIL first_instr: got v=%b pc=%h d=%h want v=1 pc=00000080 d=00000013",
                     bus.instr_valid_o, bus.instr_pc_o, bus.instr_rdata_o);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h84 ||
            bus.instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq_addr: got req=%b addr=%h v=%b want req=1 addr=00000084 v=0",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_o);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_hold_stall();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h84 ||
                bus.instr_rdata_o !== 32'hA5A5_0001 || bus.instr_req_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_stable[%0d]: got v=%b pc=%h d=%h req=%b want 1/84/a5a50001/0",
                         i, bus.instr_valid_o, bus.instr_pc_o, bus.instr_rdata_o,
                         bus.instr_req_o);
            end
            if (i < 5) @(negedge clk);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h88 ||
            bus.instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: got req=%b addr=%h v=%b want req=1 addr=00000088 v=0",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_o);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_wait();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1000);
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_wait_idle: got req=%b v=%b want 0/0",
                     bus.instr_req_o, bus.instr_valid_o);
        end
        set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid_o !== 1'b0 || bus.instr_req_o !== 1'b1 ||
            bus.instr_addr_o !== 32'h1000) begin
            tests_failed++;
            $display("FAIL redir_wait_drop: got v=%b req=%b addr=%h want v=0 req=1 addr=00001000",
                     bus.instr_valid_o, bus.instr_req_o, bus.instr_addr_o);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_req();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h1000) begin
            tests_failed++;
            $display("FAIL redir_req_hold0: got req=%b addr=%h want req=1 addr=00001000",
                     bus.instr_req_o, bus.instr_addr_o);
        end
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h1000) begin
            tests_failed++;
            $display("FAIL redir_req_hold1: got req=%b addr=%h want req=1 addr=00001000",
                     bus.instr_req_o, bus.instr_addr_o);
        end
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid_o !== 1'b0 || bus.instr_req_o !== 1'b1 ||
            bus.instr_addr_o !== 32'h200) begin
            tests_failed++;
            $display("FAIL redir_req_drop: got v=%b req=%b addr=%h want v=0 req=1 addr=00000200",
                     bus.instr_valid_o, bus.instr_req_o, bus.instr_addr_o);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        // Redirect coincident with gnt: the granted request is stale.
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'hFFFF_FFFC ||
            bus.instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_req: got req=%b addr=%h v=%b want req=1 addr=fffffffc v=0",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_o);
        end
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'hFFFF_FFFC ||
            bus.instr_rdata_o !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL wrap_instr: got v=%b pc=%h d=%h want v=1 pc=fffffffc d=12345678",
                     bus.instr_valid_o, bus.instr_pc_o, bus.instr_rdata_o);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=00000000",
                     bus.instr_req_o, bus.instr_addr_o);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_misalign();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.fetch_err_o !== ErrEn) begin
            tests_failed++; $display("FAIL misalign_err: got %b want %b", bus.fetch_err_o, ErrEn);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.fetch_err_o !== ErrEn || bus.instr_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL misalign_sticky: got err=%b addr=%h want err=%b addr=00000000",
                     bus.fetch_err_o, bus.instr_addr_o, ErrEn);
        end
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h100 ||
            bus.fetch_err_o !== ErrEn || bus.instr_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_addr: got req=%b addr=%h err=%b v=%b want 1/00000100/%b/0",
                     bus.instr_req_o, bus.instr_addr_o, bus.fetch_err_o, bus.instr_valid_o,
                     ErrEn);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Transaction-level model: tracks the pending request, the single outstanding
    // memory access (and whether a redirect made it stale) and the word owed to Issue.
    task automatic test_random();
        logic [31:0] exp_pc, req_addr_e, out_addr, pc_e, data_e, rd, tgt, t_al;
        logic idle, need_req, req_stale, outst, out_stale, valid_e, err_e;
        logic was_valid, deliver, new_req, g, rv, rdy, r;
        test_reset();
        exp_pc = 32'h80; req_addr_e = 32'h0; out_addr = 32'h0; pc_e = 32'h0; data_e = 32'h0;
        idle = 1'b1; need_req = 1'b0; req_stale = 1'b0; outst = 1'b0; out_stale = 1'b0;
        valid_e = 1'b0; err_e = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            g   = need_req && ($urandom_range(2) != 0);
            rv  = outst && ($urandom_range(1) == 1);
            rd  = $urandom;
            rdy = ($urandom_range(3) != 0);
            r   = ($urandom_range(7) == 0);
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC | ($urandom & 32'h3)) : $urandom;
            set_in(g, rv, rd, rdy, r, tgt);
            t_al      = tgt & 32'hFFFF_FFFC;
            was_valid = valid_e;
            deliver   = 1'b0;
            new_req   = idle;
            idle      = 1'b0;
            if (outst && rv) begin
                outst = 1'b0;
                if (out_stale || r) begin
                    new_req = 1'b1;
                end else begin
                    deliver = 1'b1; valid_e = 1'b1; pc_e = out_addr; data_e = rd;
                end
            end else if (outst && r) begin
                out_stale = 1'b1;
            end
            if (need_req && g) begin
                need_req = 1'b0; outst = 1'b1; out_addr = req_addr_e;
                out_stale = req_stale | r;
            end else if (need_req && r) begin
                req_stale = 1'b1;
            end
            if (was_valid && (rdy || r)) begin
                valid_e = 1'b0; new_req = 1'b1;
            end
            exp_pc = r ? t_al : (deliver ? pc_e + 32'd4 : exp_pc);
            if (new_req) begin
                need_req = 1'b1; req_addr_e = exp_pc; req_stale = 1'b0;
            end
            if (ErrEn && r && (tgt[1:0] != 2'b00)) err_e = 1'b1;
            @(negedge clk);
            tests_run += 3;
            if (bus.instr_valid_o !== valid_e) begin
                tests_failed++;
                $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.instr_valid_o, valid_e);
            end
            if (bus.instr_req_o !== need_req) begin
                tests_failed++;
                $display("FAIL rnd_req@%0d: got %b want %b", cyc, bus.instr_req_o, need_req);
            end
            if (bus.fetch_err_o !== err_e) begin
                tests_failed++;
                $display("FAIL rnd_err@%0d: got %b want %b", cyc, bus.fetch_err_o, err_e);
            end
            if (valid_e) begin
                tests_run++;
                if (bus.instr_pc_o !== pc_e || bus.instr_rdata_o !== data_e) begin
                    tests_failed++;
                    $display("FAIL rnd_instr@%0d: got pc=%h d=%h want pc=%h d=%h", cyc,
                             bus.instr_pc_o, bus.instr_rdata_o, pc_e, data_e);
                end
            end
            if (need_req) begin
                tests_run++;
                if (bus.instr_addr_o !== req_addr_e) begin
                    tests_failed++;
                    $display("FAIL rnd_addr@%0d: got %h want %h", cyc, bus.instr_addr_o,
                             req_addr_e);
                end
            end
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_req();
        test_wrap();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
